// File: rtl/grid_cell_streamer.sv
// grid_cell_streamer: walks a synchronous character ROM holding the puzzle
// text and emits each '@' / '.' as a grid cell over a valid/ready handshake.
// Newlines advance the row, CR is skipped, NUL (or the end of memory) ends
// the scan. Grid dimensions and a sticky format-error flag are reported.
module grid_cell_streamer #(
  parameter int MEM_DEPTH = 32768,
  parameter int ADDR_W    = 15,
  parameter int COL_W     = 8,
  parameter int ROW_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              cell_valid,
  input  logic              cell_ready,
  output logic              cell_roll,
  output logic [ROW_W-1:0]  cell_row,
  output logic [COL_W-1:0]  cell_col,
  output logic              busy,
  output logic              done,
  output logic [ROW_W-1:0]  rows,
  output logic [COL_W-1:0]  cols,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DECODE, S_EMIT, S_DONE} state_t;

  localparam logic [COL_W-1:0] COL_MAX = '1;
  localparam logic [ROW_W-1:0] ROW_MAX = '1;

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_NUL   = 8'h00;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ROW_W-1:0]  row_cnt;
  logic [COL_W-1:0]  col_cnt;
  logic              nl_seen;   // first non-blank newline already latched cols

  // One extra bit so MEM_DEPTH == 2^ADDR_W is still detectable.
  logic [ADDR_W:0]   addr_inc;
  logic              addr_end;
  logic              col_sat;
  logic              row_sat;
  logic [COL_W-1:0]  col_nxt;
  logic [ROW_W-1:0]  row_nxt;

  assign addr_inc = {1'b0, addr} + (ADDR_W+1)'(1);
  assign addr_end = (addr_inc == (ADDR_W+1)'(MEM_DEPTH));
  assign col_sat  = (col_cnt == COL_MAX);
  assign row_sat  = (row_cnt == ROW_MAX);
  assign col_nxt  = col_sat ? col_cnt : col_cnt + COL_W'(1);
  assign row_nxt  = row_sat ? row_cnt : row_cnt + ROW_W'(1);

  // The ROM address is the address counter itself; it never leaves range
  // because the counter is not advanced on the final increment.
  assign mem_addr = addr;

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      nl_seen    <= 1'b0;
      cell_valid <= 1'b0;
      cell_roll  <= 1'b0;
      cell_row   <= '0;
      cell_col   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rows       <= '0;
      cols       <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr    <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            nl_seen <= 1'b0;
            rows    <= '0;
            cols    <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
            state   <= S_READ;
          end
        end

        // Address is presented this cycle; ROM data arrives in DECODE.
        S_READ: state <= S_DECODE;

        S_DECODE: begin
          case (mem_data)
            CH_ROLL, CH_EMPTY: begin
              cell_roll  <= (mem_data == CH_ROLL);
              cell_row   <= row_cnt;
              cell_col   <= col_cnt;
              cell_valid <= 1'b1;
              state      <= S_EMIT;
            end

            CH_LF: begin
              // Blank lines leave row/col and cols untouched.
              if (col_cnt != '0) begin
                if (!nl_seen) begin
                  cols    <= col_cnt;
                  nl_seen <= 1'b1;
                end else if (col_cnt != cols) begin
                  err <= 1'b1;
                end
                if (row_sat) err <= 1'b1;
                row_cnt <= row_nxt;
                col_cnt <= '0;
              end
              if (addr_end) begin
                // Column is zero after a newline, so no partial row to add;
                // cols is either latched above or still zero from start.
                rows  <= (col_cnt != '0) ? row_nxt : row_cnt;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                addr  <= addr_inc[ADDR_W-1:0];
                state <= S_READ;
              end
            end

            CH_NUL: begin
              rows  <= (col_cnt != '0) ? row_nxt : row_cnt;
              if (!nl_seen) cols <= col_cnt;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end

            default: begin
              // CR is silently skipped; anything else is a format error.
              if (mem_data != CH_CR) err <= 1'b1;
              if (addr_end) begin
                rows  <= (col_cnt != '0) ? row_nxt : row_cnt;
                if (!nl_seen) cols <= col_cnt;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                addr  <= addr_inc[ADDR_W-1:0];
                state <= S_READ;
              end
            end
          endcase
        end

        // Cell outputs hold until the consumer takes the cell.
        S_EMIT: begin
          if (cell_ready) begin
            cell_valid <= 1'b0;
            col_cnt    <= col_nxt;
            if (col_sat) err <= 1'b1;
            if (addr_end) begin
              // The row just emitted a cell, so it always counts.
              rows  <= row_nxt;
              if (!nl_seen) cols <= col_nxt;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              addr  <= addr_inc[ADDR_W-1:0];
              state <= S_READ;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/grid_cell_streamer.md
Name: grid_cell_streamer

Overview:
- Producer side of the Day 4 grid interface: walks the puzzle-input character memory and emits one grid cell per valid/ready handshake, tagged with row/column coordinates.
- The roll-counting logic that produces the 32-bit sum consumes these cells.
- Parses the raw ASCII text ('@', '.', newline, CR, NUL) so downstream logic only ever sees clean cells.
- Also reports grid dimensions and a sticky format-error flag.

Parameters:
- MEM_DEPTH, 32768: number of bytes in the character memory. Scanning stops at this address if no NUL is found.
- ADDR_W, 15: memory address width; must satisfy 2^ADDR_W >= MEM_DEPTH.
- COL_W, 8: width of the column coordinate and column count.
- ROW_W, 8: width of the row coordinate and row count.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin a scan. Sampled only in IDLE or DONE.
- mem_addr  output  ADDR_W  read address to a synchronous character ROM.
- mem_data  input  8  ROM data for mem_addr, valid 1 cycle after the address is presented.
- cell_valid  output  1  cell outputs hold a cell.
- cell_ready  input  1  consumer accepts the cell. A transfer occurs when cell_valid and cell_ready are both 1.
- cell_roll  output  1  1 for '@' (0x40), 0 for '.' (0x2E).
- cell_row  output  ROW_W  row of the current cell, 0-based.
- cell_col  output  COL_W  column of the current cell, 0-based.
- busy  output  1  high from start acceptance until DONE is entered.
- done  output  1  level; high in DONE.
- rows  output  ROW_W  number of grid rows found; valid while done is high.
- cols  output  COL_W  width of the first row; valid while done is high.
- err  output  1  sticky format error; cleared by reset or a new start.

Behaviour:
- Reset (asynchronous, any state, including mid-scan or mid-handshake):
  - state = IDLE.
  - All outputs 0: mem_addr, cell_*, busy, done, rows, cols, err.
  - Internal address, row and column counters cleared.
  - A pending cell is dropped; the consumer must also reset.
- States: IDLE, READ, DECODE, EMIT, DONE.
- IDLE: on start=1:
  - Clear the address, row and column counters, cols, rows and err.
  - busy = 1; go to READ.
- READ: mem_addr holds the address counter for one cycle; go to DECODE. The ROM output is consumed in DECODE.
- DECODE: act on mem_data.
  - 0x40 or 0x2E:
    - Register cell_roll, cell_row = row counter, cell_col = column counter.
    - cell_valid = 1 from the next cycle; go to EMIT.
  - 0x0A (newline):
    - If the column counter is 0 (blank line), ignore it.
    - Otherwise: on the first newline, latch cols = column counter. On later newlines, if the column counter differs from cols, set err.
    - Then row counter += 1, column counter = 0.
    - Address += 1; go to READ.
  - 0x0D (CR): skip. Address += 1; go to READ.
  - 0x00 (NUL): terminator; go to DONE.
  - Any other byte: set err, skip. Address += 1; go to READ.
- End of memory: after any address increment that reaches MEM_DEPTH, go to DONE instead of READ. Never read out of range.
- EMIT:
  - cell_valid, cell_roll, cell_row and cell_col are held stable until the handshake.
  - On handshake: cell_valid = 0 on the next cycle, column counter += 1, address += 1, go to READ (or DONE at end of memory).
  - Column counter saturates at 2^COL_W-1 and sets err; row counter behaves the same at 2^ROW_W-1.
- Entering DONE:
  - rows = row counter + (column counter != 0 ? 1 : 0), so a last line without a trailing newline still counts.
  - If no newline was seen, cols = column counter.
  - busy = 0, done = 1.
- DONE:
  - Outputs hold.
  - start=1 restarts exactly as from IDLE: done drops the next cycle, busy rises.
- start in READ, DECODE or EMIT is ignored.
- Throughput: 3 cycles per cell with cell_ready held at 1 (READ, DECODE, EMIT/handshake); 2 cycles per skipped character.
- Latency: the first cell_valid appears 3 cycles after start is sampled, for a '@' or '.' at address 0.

Test Plan:
- ROM "@.@\n.@.\n\0", cell_ready held at 1 → 6 cells (roll,row,col): (1,0,0) (0,0,1) (1,0,2) (0,1,0) (1,1,1) (0,1,2). Then done=1, rows=2, cols=3, err=0. First cell_valid 3 cycles after start.
- Same ROM, cell_ready toggled 1-0-0-1 pseudo-randomly → identical cell sequence. No cell duplicated or lost, outputs stable while valid && !ready.
- ROM "@@\r\n..\n\n\0" (CRLF plus a blank line) → 4 cells, rows=2, cols=2, err=0.
- ROM "@.\n@\nx\0" → cells (1,0,0) (0,0,1) (1,1,0), err=1 (short row and illegal 'x'), rows=2, cols=2.
- ROM with no NUL, filled with '.' and MEM_DEPTH=16 → exactly 16 cells, then done=1, rows=1, cols=16, mem_addr never exceeds 15.
- Reset asserted while cell_valid=1 in EMIT → all outputs 0 immediately (asynchronous). After release, start rescans from address 0 and the first cell is (row 0, col 0).
